vga_tile_controller: RTL and testbench

- Parametrised VGA scan-out engine: integrated H/V timing generator plus tile-mapped frame-memory fetch pipeline.
- Drives HSYNC/VSYNC/RGB pins directly. Reads one colour word per tile from external synchronous video memory (BRAM).
- Latency compensation keeps syncs aligned with colour data for any memory latency.
- Optional built-in colour-bar test pattern, switched only on frame boundaries.

---
 rtl/vga_tile_controller.sv | 150 +++++++++++++++
 tb/tb_vga_tile_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_controller.sv
// VGA scan-out engine: H/V timing generator feeding a tile-mapped memory fetch.
// Syncs, blanking and frame marker ride a delay line so they meet the fetched colour.
module vga_tile_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 11,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 524,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int COLOR_W     = 4,
  parameter int TILE_SHIFT  = 3,
  parameter int ADDR_W      = 14,
  parameter int MEM_LATENCY = 1,
  parameter int BAR_SHIFT   = 6
) (
  input  logic                   PIXEL_CLK,
  input  logic                   RESET,
  input  logic                   TEST_PATTERN,
  output logic [ADDR_W-1:0]      VGA_ADDR,
  input  logic [3*COLOR_W-1:0]   VGA_DATA,
  output logic                   VGA_HSYNCH,
  output logic                   VGA_VSYNCH,
  output logic [COLOR_W-1:0]     VGA_OUT_RED,
  output logic [COLOR_W-1:0]     VGA_OUT_GREEN,
  output logic [COLOR_W-1:0]     VGA_OUT_BLUE,
  output logic                   FRAME_START
);

  localparam int PIPE = MEM_LATENCY + 2;
  localparam int DL_D = PIPE - 1;
  // One spare bit so sync end positions equal to the total still fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int TILES_X = H_ACTIVE >> TILE_SHIFT;
  localparam int TILES_Y = (V_ACTIVE + (1 << TILE_SHIFT) - 1) >> TILE_SHIFT;
  localparam int PROD_W  = $clog2(TILES_X * TILES_Y + 1) + 1;

  typedef struct packed {
    logic       use_bar;
    logic [2:0] bar;
    logic       fs;
    logic       vs;
    logic       hs;
    logic       act;
  } tap_t;

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic              active;
  logic              fs_raw;
  logic              mode_q;
  logic              mode_now;
  logic [HW-1:0]     h_bar;
  logic [PROD_W-1:0] tile_idx;
  tap_t              tap_in;
  tap_t              tap_out;
  tap_t              dl [DL_D];

  always_comb begin
    tap_in   = '0;
    active   = (h < H_ACT) && (v < V_ACT);
    fs_raw   = (h == '0) && (v == '0);
    // The frame's first pixel already sees the newly sampled mode.
    mode_now = fs_raw ? TEST_PATTERN : mode_q;
    h_bar    = h >> BAR_SHIFT;
    tile_idx = PROD_W'(v >> TILE_SHIFT) * PROD_W'(TILES_X) + PROD_W'(h >> TILE_SHIFT);
    tap_in.use_bar = mode_now;
    tap_in.bar     = h_bar[2:0];
    tap_in.fs      = fs_raw;
    tap_in.vs      = (v >= VS_START) && (v < VS_END);
    tap_in.hs      = (h >= HS_START) && (h < HS_END);
    tap_in.act     = active;
  end

  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) v <= '0;
      else             v <= v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Address holds through blanking; mode changes only at the frame origin.
  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      mode_q   <= 1'b0;
      VGA_ADDR <= '0;
    end else begin
      mode_q <= mode_now;
      if (active) VGA_ADDR <= ADDR_W'(tile_idx);
    end
  end

  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DL_D; i++) dl[i] <= '0;
    end else begin
      dl[0] <= tap_in;
      for (int i = 1; i < DL_D; i++) dl[i] <= dl[i-1];
    end
  end

  assign tap_out = dl[DL_D-1];

  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      VGA_HSYNCH    <= ~HS_POL;
      VGA_VSYNCH    <= ~VS_POL;
      FRAME_START   <= 1'b0;
      VGA_OUT_RED   <= '0;
      VGA_OUT_GREEN <= '0;
      VGA_OUT_BLUE  <= '0;
    end else begin
      VGA_HSYNCH  <= tap_out.hs ? HS_POL : ~HS_POL;
      VGA_VSYNCH  <= tap_out.vs ? VS_POL : ~VS_POL;
      FRAME_START <= tap_out.fs;
      if (!tap_out.act) begin
        VGA_OUT_RED   <= '0;
        VGA_OUT_GREEN <= '0;
        VGA_OUT_BLUE  <= '0;
      end else if (tap_out.use_bar) begin
        VGA_OUT_RED   <= {COLOR_W{tap_out.bar[2]}};
        VGA_OUT_GREEN <= {COLOR_W{tap_out.bar[1]}};
        VGA_OUT_BLUE  <= {COLOR_W{tap_out.bar[0]}};
      end else begin
        {VGA_OUT_RED, VGA_OUT_GREEN, VGA_OUT_BLUE} <= VGA_DATA;
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_controller.sv
// Bench for vga_tile_controller: two instances (memory latency 1 and 3) on a small
// raster, checked every cycle against expected pixels queued when each pixel is scanned.
module tb_vga_tile_controller;

  localparam int HA = 32, HFP = 4, HSW = 6, HT = 48;
  localparam int VA = 16, VFP = 2, VSW = 2, VT = 22;
  localparam int F = HT * VT;
  localparam int PIPE_A = 3, PIPE_B = 5;
  localparam logic [14:0] BLANK = {1'b0, 1'b1, 1'b1, 12'h000};

  logic        clk = 1'b0;
  logic        rst;
  logic        tp;
  logic [13:0] addr_a, addr_b;
  logic [11:0] data_a, data_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [13:0] ma0 = '0, mb0 = '0, mb1 = '0, mb2 = '0;

  logic [14:0] exp_q_a[$], exp_q_b[$];
  logic [13:0] addr_q_a[$], addr_q_b[$];
  int  total = 0;
  int  bad = 0;
  bit  checking = 1'b0;
  int  n;
  bit  frame_mode;
  int  last_tile;

  always #5 clk = ~clk;

  vga_tile_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_TOTAL(VT),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .TILE_SHIFT(3),
    .ADDR_W(14), .MEM_LATENCY(1), .BAR_SHIFT(2)
  ) dut_a (
    .PIXEL_CLK(clk), .RESET(rst), .TEST_PATTERN(tp), .VGA_ADDR(addr_a),
    .VGA_DATA(data_a), .VGA_HSYNCH(hs_a), .VGA_VSYNCH(vs_a),
    .VGA_OUT_RED(r_a), .VGA_OUT_GREEN(g_a), .VGA_OUT_BLUE(b_a),
    .FRAME_START(fs_a)
  );

  vga_tile_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_TOTAL(VT),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .TILE_SHIFT(3),
    .ADDR_W(14), .MEM_LATENCY(3), .BAR_SHIFT(2)
  ) dut_b (
    .PIXEL_CLK(clk), .RESET(rst), .TEST_PATTERN(tp), .VGA_ADDR(addr_b),
    .VGA_DATA(data_b), .VGA_HSYNCH(hs_b), .VGA_VSYNCH(vs_b),
    .VGA_OUT_RED(r_b), .VGA_OUT_GREEN(g_b), .VGA_OUT_BLUE(b_b),
    .FRAME_START(fs_b)
  );

  function automatic logic [11:0] mem_word(input logic [13:0] a);
    if (a == 14'd0) return 12'hF00;
    return {a[3:0], ~a[3:0], 4'h3};
  endfunction

  // Synchronous memories with latency 1 and 3
  always @(posedge clk) begin
    ma0 <= addr_a;
    mb0 <= addr_b;
    mb1 <= mb0;
    mb2 <= mb1;
  end
  assign data_a = mem_word(ma0);
  assign data_b = mem_word(mb2);

  function automatic logic [14:0] expect_pix(input int h, input int v, input bit m);
    logic [11:0] rgb;
    logic [2:0]  bar;
    logic        hs, vs, fs;
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    fs = (h == 0) && (v == 0);
    rgb = 12'h000;
    if (h < HA && v < VA) begin
      if (m) begin
        bar = 3'((h >> 2) & 7);
        rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      end else begin
        rgb = mem_word(14'((v >> 3) * (HA >> 3) + (h >> 3)));
      end
    end
    return {fs, vs, hs, rgb};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic restart_model();
    exp_q_a.delete(); exp_q_b.delete();
    addr_q_a.delete(); addr_q_b.delete();
    repeat (PIPE_A) exp_q_a.push_back(BLANK);
    repeat (PIPE_B) exp_q_b.push_back(BLANK);
    addr_q_a.push_back(14'd0);
    addr_q_b.push_back(14'd0);
    n = 0;
    last_tile = 0;
    frame_mode = 1'b0;
  endtask

  // Queue the expected outputs for the pixel the counters hold this cycle.
  task automatic step_cycle();
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    if (h == 0 && v == 0) frame_mode = tp;
    exp_q_a.push_back(expect_pix(h, v, frame_mode));
    exp_q_b.push_back(expect_pix(h, v, frame_mode));
    if (h < HA && v < VA) last_tile = (v >> 3) * (HA >> 3) + (h >> 3);
    addr_q_a.push_back(14'(last_tile));
    addr_q_b.push_back(14'(last_tile));
    n++;
  endtask

  // Monitor: one expected entry per queue per cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (checking) begin
        if (exp_q_a.size() == 0 || addr_q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL queue_a empty t=%0t", $time);
        end else begin
          check("pix_a", 32'({fs_a, vs_a, hs_a, r_a, g_a, b_a}), 32'(exp_q_a.pop_front()));
          check("addr_a", 32'(addr_a), 32'(addr_q_a.pop_front()));
        end
        if (exp_q_b.size() == 0 || addr_q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL queue_b empty t=%0t", $time);
        end else begin
          check("pix_b", 32'({fs_b, vs_b, hs_b, r_b, g_b, b_b}), 32'(exp_q_b.pop_front()));
          check("addr_b", 32'(addr_b), 32'(addr_q_b.pop_front()));
        end
      end
    end
  end

  initial begin
    bit did_reset;
    bit done;
    did_reset = 1'b0;
    done = 1'b0;
    rst = 1'b1;
    tp = 1'b0;
    repeat (3) @(negedge clk);
    restart_model();
    rst = 1'b0;
    checking = 1'b1;
    step_cycle();
    while (!done) begin
      @(negedge clk);
      if (!did_reset && n == 2 * F + 10 * HT + 20) begin
        // Mid-frame reset must clear outputs without a clock edge.
        checking = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_pix_a", 32'({fs_a, vs_a, hs_a, r_a, g_a, b_a}), 32'(BLANK));
        check("rst_pix_b", 32'({fs_b, vs_b, hs_b, r_b, g_b, b_b}), 32'(BLANK));
        check("rst_addr_a", 32'(addr_a), 32'd0);
        check("rst_addr_b", 32'(addr_b), 32'd0);
        tp = 1'b1;
        repeat (4) @(negedge clk);
        restart_model();
        rst = 1'b0;
        checking = 1'b1;
        did_reset = 1'b1;
      end else if (!did_reset && n == 500) begin
        tp = 1'b1;
      end else if (!did_reset && n == F + 600) begin
        tp = 1'b0;
      end
      step_cycle();
      if (did_reset && n == F + 40) done = 1'b1;
    end
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
